if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
Pipeline register between the fetch stage and decode in the 5-stage WISC-SP13 pipeline. Each cycle it captures the fetched instruction, the incremented PC and the current PC. It supports hazard stalls (hold), branch/jump flushes (insert NOP) and HALT freezing. It also keeps a saturating stall-cycle counter for debug and performance visibility.

Parameters:
NOP_INSTR, 16'h0800, encoding inserted on reset and flush (WISC-SP13 NOP)
HALT_OPC, 5'b00000, opcode field [15:11] identifying HALT
CNT_W, 16, width of the stall counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
instr_in  input  16  instruction from fetch instruction memory
nextPC_in  input  16  PC+2 (or held PC) from fetch
currPC_in  input  16  PC of instr_in
stall  input  1  hazard unit hold request; register keeps its contents
flush  input  1  branch/jump taken in EX/MEM; squash the younger instruction
instr_out  output  16  instruction presented to decode
nextPC_out  output  16  registered nextPC_in
currPC_out  output  16  registered currPC_in
valid_out  output  1  1 = instr_out is a real fetched instruction
isNop_out  output  1  1 = instr_out is a bubble (reset/flush inserted); returned to fetch to hold the PC
halted  output  1  HALT has reached decode; stage frozen
stall_cnt  output  CNT_W  cycles with stall=1 while in RUN, saturating

Behaviour:
- Reset (async, asserted): instr_out=NOP_INSTR, nextPC_out=0, currPC_out=0, valid_out=0, isNop_out=1, halted=0, stall_cnt=0, state=EMPTY. Outputs take these values immediately on assertion, without waiting for a clock edge.
- Latency: one cycle. Values presented at edge N appear on the outputs after edge N.
- States: EMPTY (bubble held), RUN (valid instruction held), HALTED.
- Per-edge priority: flush > stall > halted-freeze > load.
- flush=1, any state: load NOP_INSTR, PCs<=currPC_in/nextPC_in, valid_out<=0, isNop_out<=1, state->EMPTY. This clears HALTED, because a HALT sitting in ID is younger than the branch and is therefore squashed.
- stall=1 (no flush): all data outputs hold, state unchanged. stall_cnt increments only in RUN and saturates at all-ones.
- HALTED (no flush): all outputs hold regardless of instr_in and stall. halted stays 1 until reset or flush.
- Load (no flush, no stall, not HALTED):
  - Capture all inputs; valid_out<=1, isNop_out<=0.
  - If instr_in[15:11]==HALT_OPC: state->HALTED and halted<=1 on the same edge. Otherwise state->RUN.
- EMPTY->RUN needs one load with a non-HALT instruction. EMPTY->HALTED is legal if the first instruction is HALT.
- stall and flush together: flush wins and stall_cnt does not increment.
- PC values pass through unmodified; no arithmetic is done on PCs here.
- rst asserted mid-stall or mid-halt: all state is cleared as above, including stall_cnt.

Test Plan:
- Reset: assert rst asynchronously between edges with instr_in=16'hC123 -> immediately instr_out=16'h0800, valid_out=0, isNop_out=1, halted=0, stall_cnt=0.
- Pipeline flow: after release, drive instr_in=16'h4A21, currPC=16'h0010, nextPC=16'h0012 -> after one edge instr_out=16'h4A21, PCs 0x0010/0x0012, valid_out=1, isNop_out=0.
- Stall for 3 cycles while instr_in changes to 16'h5555 -> outputs hold 16'h4A21 and stall_cnt=3. Deassert stall -> 16'h5555 loads on the next edge.
- Flush with stall=1 in the same cycle -> instr_out=16'h0800, valid_out=0, isNop_out=1, stall_cnt unchanged.
- HALT: load instr_in=16'h0000 -> halted=1. Then drive 16'h4A21 for 5 cycles -> instr_out stays 16'h0000. Then flush=1 -> instr_out=16'h0800, halted=0.
- Saturation: preset near max (CNT_W=4 build) and stall 20 cycles in RUN -> stall_cnt=4'hF with no wrap.

Source files
------------

// File: rtl/if_id_if.sv
// if_id_if: fetch-to-decode bundle carried through the IF/ID pipeline register.
interface if_id_if #(parameter int CNT_W = 16);
  logic [15:0] instr_in, nextPC_in, currPC_in;
  logic stall, flush;
  logic [15:0] instr_out, nextPC_out, currPC_out;
  logic valid_out, isNop_out, halted;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output instr_in, nextPC_in, currPC_in, stall, flush,
    input instr_out, nextPC_out, currPC_out, valid_out, isNop_out, halted, stall_cnt
  );
  modport slave (
    input instr_in, nextPC_in, currPC_in, stall, flush,
    output instr_out, nextPC_out, currPC_out, valid_out, isNop_out, halted, stall_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with stall hold, flush-to-NOP, HALT freeze and a saturating stall counter.
module if_id_stage #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0] HALT_OPC = 5'b00000,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  if_id_if.slave bus
);
  localparam logic [1:0] EMPTY = 2'd0, RUN = 2'd1, HALTED = 2'd2;
  logic [1:0] state;
  logic [15:0] instr, next_pc, curr_pc;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      instr <= NOP_INSTR;
      next_pc <= '0;
      curr_pc <= '0;
      cnt <= '0;
    end else if (bus.flush) begin
      state <= EMPTY;
      instr <= NOP_INSTR;
      next_pc <= bus.nextPC_in;
      curr_pc <= bus.currPC_in;
    end else if (bus.stall) begin
      if (state == RUN && cnt != '1) cnt <= cnt + 1'b1;
    end else if (state != HALTED) begin
      state <= (bus.instr_in[15:11] == HALT_OPC) ? HALTED : RUN;
      instr <= bus.instr_in;
      next_pc <= bus.nextPC_in;
      curr_pc <= bus.currPC_in;
    end
  end
  // valid/bubble/halt flags are pure functions of the held state
  assign bus.instr_out = instr;
  assign bus.nextPC_out = next_pc;
  assign bus.currPC_out = curr_pc;
  assign bus.valid_out = state != EMPTY;
  assign bus.isNop_out = state == EMPTY;
  assign bus.halted = state == HALTED;
  assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed stimulus with a behavioural model checked every cycle plus literal spot checks.
module tb_if_id_stage;
  logic clk = 0, rst;
  logic [15:0] instr, next_pc, curr_pc;
  logic stall, flush, chk_on = 0;
  int total = 0, bad = 0;
  if_id_if #(16) b16 ();
  if_id_if #(4) b4 ();
  assign b16.instr_in = instr;
  assign b16.nextPC_in = next_pc;
  assign b16.currPC_in = curr_pc;
  assign b16.stall = stall;
  assign b16.flush = flush;
  assign b4.instr_in = instr;
  assign b4.nextPC_in = next_pc;
  assign b4.currPC_in = curr_pc;
  assign b4.stall = stall;
  assign b4.flush = flush;
  if_id_stage #(.CNT_W(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
  if_id_stage #(.CNT_W(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  always #5 clk = ~clk;

  logic [15:0] m_instr, m_next, m_curr;
  logic m_valid, m_halt;
  int m_cnt, m_cnt4;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_instr = 16'h0800; m_next = 0; m_curr = 0;
      m_valid = 0; m_halt = 0; m_cnt = 0; m_cnt4 = 0;
    end else if (flush) begin
      m_instr = 16'h0800; m_next = next_pc; m_curr = curr_pc;
      m_valid = 0; m_halt = 0;
    end else if (stall) begin
      if (m_valid && !m_halt) begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        m_cnt4 = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
      end
    end else if (!m_halt) begin
      m_instr = instr; m_next = next_pc; m_curr = curr_pc;
      m_valid = 1; m_halt = (instr >> 11) == 0;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("m_instr", b16.instr_out, m_instr);
    chk("m_next", b16.nextPC_out, m_next);
    chk("m_curr", b16.currPC_out, m_curr);
    chk("m_valid", b16.valid_out, m_valid);
    chk("m_isnop", b16.isNop_out, !m_valid);
    chk("m_halted", b16.halted, m_halt);
    chk("m_cnt", b16.stall_cnt, m_cnt);
    chk("m_cnt4", b4.stall_cnt, m_cnt4);
    chk("m_instr4", b4.instr_out, m_instr);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [15:0] i, input logic [15:0] c, input logic s, input logic f);
    instr = i; curr_pc = c; next_pc = c + 16'd2; stall = s; flush = f;
  endtask

  initial begin
    rst = 1;
    drive(16'h0000, 16'h0000, 0, 0);
    step(2);
    rst = 0; chk_on = 1;
    chk("rst_instr", b16.instr_out, 16'h0800);
    chk("rst_valid", b16.valid_out, 0);
    chk("rst_isnop", b16.isNop_out, 1);
    drive(16'h4A21, 16'h0010, 0, 0);
    step();
    chk("flow_instr", b16.instr_out, 16'h4A21);
    chk("flow_curr", b16.currPC_out, 16'h0010);
    chk("flow_next", b16.nextPC_out, 16'h0012);
    chk("flow_valid", b16.valid_out, 1);
    chk("flow_isnop", b16.isNop_out, 0);
    drive(16'h5555, 16'h0012, 1, 0);
    step(3);
    chk("stall_hold", b16.instr_out, 16'h4A21);
    chk("stall_cnt3", b16.stall_cnt, 3);
    stall = 0;
    step();
    chk("unstall_load", b16.instr_out, 16'h5555);
    drive(16'h6666, 16'h0020, 1, 1);
    step();
    chk("flush_instr", b16.instr_out, 16'h0800);
    chk("flush_valid", b16.valid_out, 0);
    chk("flush_isnop", b16.isNop_out, 1);
    chk("flush_cnt", b16.stall_cnt, 3);
    chk("flush_curr", b16.currPC_out, 16'h0020);
    drive(16'h0000, 16'h0030, 0, 0);
    step();
    chk("halt_set", b16.halted, 1);
    chk("halt_instr", b16.instr_out, 16'h0000);
    drive(16'h4A21, 16'h0032, 0, 0);
    step(3);
    stall = 1;
    step(2);
    chk("halt_freeze", b16.instr_out, 16'h0000);
    chk("halt_curr", b16.currPC_out, 16'h0030);
    chk("halt_nocnt", b16.stall_cnt, 3);
    drive(16'h4A21, 16'h0040, 0, 1);
    step();
    chk("halt_flush_instr", b16.instr_out, 16'h0800);
    chk("halt_flush_halted", b16.halted, 0);
    drive(16'h1234, 16'h0042, 0, 0);
    step();
    chk("nohalt_0800_pre", b16.halted, 0);
    stall = 1;
    step(20);
    chk("sat4", b4.stall_cnt, 4'hF);
    chk("cnt16_23", b16.stall_cnt, 23);
    instr = 16'hC123;
    rst = 1;
    #1;
    chk("arst_instr", b16.instr_out, 16'h0800);
    chk("arst_valid", b16.valid_out, 0);
    chk("arst_isnop", b16.isNop_out, 1);
    chk("arst_halted", b16.halted, 0);
    chk("arst_cnt", b16.stall_cnt, 0);
    step();
    rst = 0;
    drive(16'h0800, 16'h0100, 0, 0);
    step();
    chk("nop_not_halt", b16.halted, 0);
    chk("nop_valid", b16.valid_out, 1);
    drive(16'h07FF, 16'h0102, 0, 0);
    step();
    chk("halt_07ff", b16.halted, 1);
    rst = 1;
    #1;
    rst = 0;
    drive(16'h0000, 16'h0200, 0, 0);
    step();
    chk("empty_to_halt", b16.halted, 1);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
